data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter: DATA_W, default 32, data width of both requesters and the memory port.
REQ-003 Port: clk, in, 1, single clock for all state; data memory writes on the same edge.
REQ-004 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-005 Ports: CPU_REQ in 1, CPU_WE in 1, CPU_ADDR in ADDR_W, CPU_WDATA in DATA_W: pipeline MEM-stage request. CPU_WE is 1 for a store and 0 for a load.
REQ-006 Ports: CPU_ACK out 1, CPU_RDATA out DATA_W, CPU_STALL out 1: completion, load data and pipeline hold.
REQ-007 Ports: DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_ACK, DMA_RDATA: loader/debug requester, with the same widths and meanings as the CPU ports.
REQ-008 Ports: MEM_READ out 1, MEM_WRITE out 1, ADDRESS_MEM out ADDR_W, WRITE_DATA out DATA_W, READ_DATA in DATA_W: single data_memory port; read data is combinational.

Function
REQ-009 FSM states: IDLE, ACCESS, RESP.
REQ-010 IDLE: if any eligible REQ is high, latch the winner's WE, ADDR and WDATA plus the grant index, then go to ACCESS. Otherwise stay in IDLE.
REQ-011 ACCESS (exactly one cycle):
- Drive MEM_WRITE=WE and MEM_READ=~WE from the latched fields.
- Drive ADDRESS_MEM and WRITE_DATA from the latched fields.
- Capture READ_DATA into the winner's RDATA register at the clock edge.
- Go to RESP.
REQ-012 RESP: assert the winner's ACK for exactly one cycle. RDATA is valid in the ACK cycle and holds until that port's next ACK. Arbitrate as in IDLE and go to ACCESS or IDLE.
REQ-013 Latency: REQ sampled in cycle N produces ACCESS in N+1 and ACK in N+2. Sustained throughput is one access per 2 cycles.
REQ-014 Eligibility: in RESP, the port being acknowledged is not eligible. A held REQ from that port is treated as a new request from the next cycle onward.
REQ-015 Requester rule: REQ, WE, ADDR and WDATA stay stable from assertion until ACK. The arbiter latches them at grant, so later changes have no effect on the granted access.
REQ-016 Round-robin arbitration:
- A 1-bit LAST register records the most recently granted port (0=CPU, 1=DMA).
- When both ports are eligible, grant the port other than LAST.
- When one port is eligible, grant it.
- Update LAST on every grant.
REQ-017 Outside ACCESS, MEM_READ=MEM_WRITE=0. ADDRESS_MEM and WRITE_DATA hold their latched values.
REQ-018 CPU_STALL = CPU_REQ & ~CPU_ACK (combinational).
REQ-019 Writes and reads to the same address in successive grants are strictly ordered. A read granted after a write returns the written data.

Reset
REQ-020 reset_n low sets the outputs and state as follows, asynchronously and independent of clk:
- state=IDLE and LAST=1, so the CPU wins the first tie.
- CPU_ACK=DMA_ACK=0 and MEM_READ=MEM_WRITE=0.
- CPU_RDATA, DMA_RDATA, ADDRESS_MEM and WRITE_DATA are 0.
REQ-021 Reset during ACCESS or RESP aborts the transaction: no ACK is issued, and a write is not retried. The requester re-issues it after reset.
REQ-022 Reset deassertion is synchronized externally. The first arbitration happens on the first rising clk edge with reset_n high.

Structure
REQ-023 Shared package mem_arb_pkg holds:
- the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
- port indices PORT_CPU=0 and PORT_DMA=1;
- the default widths.
REQ-024 One sub-module, rr_arbiter2, SHALL implement the combinational two-way round-robin pick: inputs eligible[1:0] and LAST; outputs grant_valid and grant_idx.
REQ-025 data_memory is instantiated outside this block; its address-decode behaviour is unchanged.

Verification
REQ-026 CPU store, then load: CPU_REQ=1, WE=1, ADDR=0x10, WDATA=0xDEADBEEF at N -> MEM_WRITE=1 at N+1, CPU_ACK at N+2. A CPU load from 0x10 -> CPU_RDATA=0xDEADBEEF with its ACK.
REQ-027 Simultaneous requests after reset: CPU and DMA both request at the same time -> CPU is granted first and DMA second. ACKs arrive at N+2 and N+4, and LAST=1 at the end.
REQ-028 Fairness: CPU_REQ and DMA_REQ held high with each re-request issued right after its ACK -> grants alternate CPU, DMA, CPU, DMA. No port receives 2 consecutive grants.
REQ-029 Stall: DMA load in progress while CPU_REQ rises -> CPU_STALL=1 until the CPU_ACK cycle, then 0. The pipeline latch holds 0x00000042 unchanged.
REQ-030 Reset in ACCESS: reset_n=0 in the ACCESS cycle of a DMA write of 0x5 to 0x20 -> all ACKs=0 and state=IDLE. No ACK follows release, and the bench checks that the memory port is idle.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared encodings and default widths for the data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU/DMA requester and data memory signals of the arbiter
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              CPU_REQ;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_ACK;
  logic [DATA_W-1:0] CPU_RDATA;
  logic              CPU_STALL;

  logic              DMA_REQ;
  logic              DMA_WE;
  logic [ADDR_W-1:0] DMA_ADDR;
  logic [DATA_W-1:0] DMA_WDATA;
  logic              DMA_ACK;
  logic [DATA_W-1:0] DMA_RDATA;

  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] ADDRESS_MEM;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [DATA_W-1:0] READ_DATA;

  // arbiter side
  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output CPU_ACK, CPU_RDATA, CPU_STALL,
    input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
    output DMA_ACK, DMA_RDATA,
    output MEM_READ, MEM_WRITE, ADDRESS_MEM, WRITE_DATA,
    input  READ_DATA
  );

  // requesters and data memory side
  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  CPU_ACK, CPU_RDATA, CPU_STALL,
    output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
    input  DMA_ACK, DMA_RDATA,
    input  MEM_READ, MEM_WRITE, ADDRESS_MEM, WRITE_DATA,
    output READ_DATA
  );

endinterface

// File: rtl/data_mem_arbiter_rr.sv
// rtl/data_mem_arbiter_rr.sv - combinational two-way round-robin pick
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    case (eligible)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares one data memory port between the CPU MEM stage and a DMA requester
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          reset_n,
  data_mem_arbiter_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_last;
  logic              r_gidx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic [1:0]        w_eligible;
  logic              w_grant_valid;
  logic              w_grant_idx;
  logic              w_take_grant;
  logic              w_cpu_ack;
  logic              w_dma_ack;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  // the port being acknowledged sits out this round, so a held REQ counts as new next cycle
  always_comb begin
    w_eligible = {bus.DMA_REQ, bus.CPU_REQ};
    if (r_state == RESP) begin
      w_eligible[r_gidx] = 1'b0;
    end
  end

  rr_arbiter2 u_rr (
    .eligible    (w_eligible),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_win_we    = w_grant_idx ? bus.DMA_WE    : bus.CPU_WE;
  assign w_win_addr  = w_grant_idx ? bus.DMA_ADDR  : bus.CPU_ADDR;
  assign w_win_wdata = w_grant_idx ? bus.DMA_WDATA : bus.CPU_WDATA;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_take_grant  = 1'b0;
    w_cpu_ack     = 1'b0;
    w_dma_ack     = 1'b0;
    bus.MEM_READ  = 1'b0;
    bus.MEM_WRITE = 1'b0;
    case (r_state)
      IDLE: begin
        w_take_grant = w_grant_valid;
        w_state_nxt  = w_grant_valid ? ACCESS : IDLE;
      end
      ACCESS: begin
        bus.MEM_WRITE = r_we;
        bus.MEM_READ  = ~r_we;
        w_state_nxt   = RESP;
      end
      RESP: begin
        w_cpu_ack    = (r_gidx == PORT_CPU);
        w_dma_ack    = (r_gidx == PORT_DMA);
        w_take_grant = w_grant_valid;
        w_state_nxt  = w_grant_valid ? ACCESS : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // LAST resets to DMA so the CPU wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= PORT_DMA;
      r_gidx      <= PORT_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_take_grant) begin
        r_gidx  <= w_grant_idx;
        r_last  <= w_grant_idx;
        r_we    <= w_win_we;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
      if (r_state == ACCESS) begin
        if (r_gidx == PORT_DMA) begin
          r_dma_rdata <= bus.READ_DATA;
        end else begin
          r_cpu_rdata <= bus.READ_DATA;
        end
      end
    end
  end

  assign bus.ADDRESS_MEM = r_addr;
  assign bus.WRITE_DATA  = r_wdata;
  assign bus.CPU_ACK     = w_cpu_ack;
  assign bus.DMA_ACK     = w_dma_ack;
  assign bus.CPU_RDATA   = r_cpu_rdata;
  assign bus.DMA_RDATA   = r_dma_rdata;
  assign bus.CPU_STALL   = bus.CPU_REQ & ~w_cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter against a transaction-level model
module tb_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // stand-in for the external data_memory: combinational read, write on the clock edge
  logic [DW-1:0] dmem [0:255] = '{default: '0};
  assign bus.READ_DATA = dmem[bus.ADDRESS_MEM[7:0]];
  always @(posedge clk) begin
    if (bus.MEM_WRITE) dmem[bus.ADDRESS_MEM[7:0]] <= bus.WRITE_DATA;
  end

  // model: a grant occupies one memory cycle then one acknowledge cycle
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};
  int            m_phase = 0;
  bit            m_port  = 1'b0;
  bit            m_last  = 1'b1;
  bit            m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata [0:1] = '{default: '0};

  always @(posedge clk or negedge reset_n) begin : model
    bit want_c, want_d, pick;
    if (!reset_n) begin
      m_phase = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_phase == 1) begin
      m_rdata[m_port] = ref_mem[m_addr[7:0]];
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      m_phase = 2;
    end else begin
      want_c = bus.CPU_REQ && !(m_phase == 2 && m_port == 1'b0);
      want_d = bus.DMA_REQ && !(m_phase == 2 && m_port == 1'b1);
      if (want_c || want_d) begin
        pick    = (want_c && want_d) ? !m_last : want_d;
        m_port  = pick;
        m_last  = pick;
        m_we    = pick ? bus.DMA_WE    : bus.CPU_WE;
        m_addr  = pick ? bus.DMA_ADDR  : bus.CPU_ADDR;
        m_wdata = pick ? bus.DMA_WDATA : bus.CPU_WDATA;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int ack_log[$];

  always @(negedge clk) begin
    bit e_cack, e_dack;
    e_cack = (m_phase == 2) && (m_port == 1'b0);
    e_dack = (m_phase == 2) && (m_port == 1'b1);
    check("cmp_cpu_ack",   64'(bus.CPU_ACK),     64'(e_cack));
    check("cmp_dma_ack",   64'(bus.DMA_ACK),     64'(e_dack));
    check("cmp_mem_write", 64'(bus.MEM_WRITE),   64'((m_phase == 1) && m_we));
    check("cmp_mem_read",  64'(bus.MEM_READ),    64'((m_phase == 1) && !m_we));
    check("cmp_addr",      64'(bus.ADDRESS_MEM), 64'(m_addr));
    check("cmp_wdata",     64'(bus.WRITE_DATA),  64'(m_wdata));
    check("cmp_cpu_rdata", 64'(bus.CPU_RDATA),   64'(m_rdata[0]));
    check("cmp_dma_rdata", 64'(bus.DMA_RDATA),   64'(m_rdata[1]));
    check("cmp_cpu_stall", 64'(bus.CPU_STALL),   64'(bus.CPU_REQ && !e_cack));
    if (bus.CPU_ACK) ack_log.push_back(0);
    if (bus.DMA_ACK) ack_log.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_ADDR = a; bus.CPU_WDATA = d;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.DMA_REQ = req; bus.DMA_WE = we; bus.DMA_ADDR = a; bus.DMA_WDATA = d;
  endtask

  initial begin
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    repeat (2) tick();
    check("rst_cpu_ack",   64'(bus.CPU_ACK), 64'(0));
    check("rst_mem_read",  64'(bus.MEM_READ), 64'(0));
    check("rst_addr",      64'(bus.ADDRESS_MEM), 64'(0));
    check("rst_cpu_rdata", 64'(bus.CPU_RDATA), 64'(0));
    reset_n = 1'b1;
    tick();

    // CPU store then load of the same word
    set_cpu(1, 1, 32'h10, 32'hDEADBEEF);
    tick();
    check("st_mem_write", 64'(bus.MEM_WRITE), 64'(1));
    check("st_addr",      64'(bus.ADDRESS_MEM), 64'(32'h10));
    tick();
    check("st_cpu_ack",   64'(bus.CPU_ACK), 64'(1));
    set_cpu(0, 0, '0, '0);
    tick();
    set_cpu(1, 0, 32'h10, '0);
    tick();
    check("ld_mem_read",  64'(bus.MEM_READ), 64'(1));
    tick();
    check("ld_cpu_ack",   64'(bus.CPU_ACK), 64'(1));
    check("ld_cpu_rdata", 64'(bus.CPU_RDATA), 64'(32'hDEADBEEF));
    check("ld_model",     64'(m_rdata[0]), 64'(32'hDEADBEEF));
    set_cpu(0, 0, '0, '0);
    tick();

    // simultaneous requests right after reset: CPU first, DMA second
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_cpu(1, 1, 32'h30, 32'h11111111);
    set_dma(1, 1, 32'h34, 32'h22222222);
    tick();
    check("tie_first_addr", 64'(bus.ADDRESS_MEM), 64'(32'h30));
    tick();
    check("tie_cpu_ack_n2", 64'(bus.CPU_ACK), 64'(1));
    check("tie_dma_ack_n2", 64'(bus.DMA_ACK), 64'(0));
    set_cpu(0, 0, '0, '0);
    tick();
    check("tie_second_addr", 64'(bus.ADDRESS_MEM), 64'(32'h34));
    tick();
    check("tie_dma_ack_n4", 64'(bus.DMA_ACK), 64'(1));
    check("tie_model_last", 64'(m_last), 64'(1));
    set_dma(0, 0, '0, '0);
    tick();

    // fairness: both held, grants must alternate
    ack_log.delete();
    set_cpu(1, 0, 32'h30, '0);
    set_dma(1, 0, 32'h34, '0);
    repeat (8) tick();
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    check("fair_cpu_rdata", 64'(bus.CPU_RDATA), 64'(32'h11111111));
    check("fair_dma_rdata", 64'(bus.DMA_RDATA), 64'(32'h22222222));
    repeat (2) tick();
    check("fair_count", 64'(ack_log.size()), 64'(4));
    for (int i = 0; i < ack_log.size(); i++) begin
      check("fair_order", 64'(ack_log[i]), 64'(i % 2));
    end

    // CPU stalls behind a DMA load already in progress
    set_dma(1, 0, 32'h10, '0);
    tick();
    set_cpu(1, 1, 32'h40, 32'h00000042);
    #1;
    check("stall_during_dma_access", 64'(bus.CPU_STALL), 64'(1));
    tick();
    check("stall_dma_ack",   64'(bus.DMA_ACK), 64'(1));
    check("stall_dma_rdata", 64'(bus.DMA_RDATA), 64'(32'hDEADBEEF));
    check("stall_in_resp",   64'(bus.CPU_STALL), 64'(1));
    set_dma(0, 0, '0, '0);
    tick();
    check("stall_in_access", 64'(bus.CPU_STALL), 64'(1));
    check("stall_wdata",     64'(bus.WRITE_DATA), 64'(32'h42));
    tick();
    check("stall_cpu_ack",   64'(bus.CPU_ACK), 64'(1));
    check("stall_released",  64'(bus.CPU_STALL), 64'(0));
    set_cpu(0, 0, '0, '0);
    tick();
    set_dma(1, 0, 32'h40, '0);
    repeat (2) tick();
    check("raw_dma_rdata", 64'(bus.DMA_RDATA), 64'(32'h42));
    set_dma(0, 0, '0, '0);
    tick();

    // reset in the ACCESS cycle of a DMA write aborts it
    set_dma(1, 1, 32'h20, 32'h5);
    tick();
    check("abort_mem_write", 64'(bus.MEM_WRITE), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_dma_ack",   64'(bus.DMA_ACK), 64'(0));
    check("abort_cpu_ack",   64'(bus.CPU_ACK), 64'(0));
    check("abort_write_off", 64'(bus.MEM_WRITE), 64'(0));
    check("abort_addr",      64'(bus.ADDRESS_MEM), 64'(0));
    set_dma(0, 0, '0, '0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_dma_ack",   64'(bus.DMA_ACK), 64'(0));
    check("post_mem_read",  64'(bus.MEM_READ), 64'(0));
    check("post_mem_write", 64'(bus.MEM_WRITE), 64'(0));
    set_cpu(1, 0, 32'h20, '0);
    repeat (2) tick();
    check("post_cpu_ack",   64'(bus.CPU_ACK), 64'(1));
    check("post_no_write",  64'(bus.CPU_RDATA), 64'(0));
    set_cpu(0, 0, '0, '0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
